alu_datapath_mc: RTL and testbench
==================================

Name: alu_datapath_mc

Overview:
Parametrised multi-cycle ALU datapath. It contains the A and B operand registers, a registered result, and a flags register. Operands load from the shared data bus. Operations are issued through a valid/ready handshake, and the result is driven back to the bus on request. It succeeds the fixed 8-bit single-op ALU with a full opcode set, a sequential multiplier, status flags and a defined latency.

Parameters:
WIDTH, 8, datapath width in bits (min 4)
OPW, 4, opcode width (fixed encoding defined in alu_pkg)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
bus_in  in  WIDTH  data bus into A/B registers
load_a  in  1  capture bus_in into A at clk edge
load_b  in  1  capture bus_in into B at clk edge
op_valid  in  1  operation request
opcode  in  OPW  operation select, sampled on accept
op_ready  out  1  block can accept an operation
result_valid  out  1  one-cycle pulse when result/flags update
busy  out  1  operation in progress
flags  out  4  {V,C,N,Z} of last completed op
send_result  in  1  drive result on bus_out
send_a  in  1  drive A on bus_out
bus_out  out  WIDTH  bus output data, 0 when bus_oe low
bus_oe  out  1  bus_out valid (send_result|send_a)

Behaviour:
- Reset (async, rst_n=0):
  - A, B, result, flags, bus_out = 0; op_ready = 1; busy = 0; result_valid = 0; FSM = IDLE.
  - Asserting reset mid-MUL aborts the operation with no result_valid pulse.
- load_a/load_b: honoured in any state. Operands are snapshotted on accept, so a load has no effect on an in-flight op.
- Accept = op_valid & op_ready. op_ready = 1 only in IDLE.
- Load and accept in the same cycle: the op uses the pre-load register value.
- Opcodes:
  - 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A.
  - 6 SHL A (by 1), 7 SHR A (logical, by 1), 8 INC A, 9 DEC A.
  - 10 MUL: low WIDTH bits of A*B, unsigned.
  - 11-15 reserved: result = 0, flags = 4'b0000, still completes.
- FSM states: IDLE, EXEC, MUL, DONE.
  - IDLE -> EXEC on accept of a non-MUL opcode.
  - IDLE -> MUL on accept of opcode 10.
  - EXEC -> DONE after 1 cycle.
  - MUL -> DONE after exactly WIDTH iterations.
  - DONE -> IDLE after 1 cycle; result, flags update and result_valid pulses in this cycle.
- Latency from accept edge to result_valid:
  - Non-MUL ops: 2 cycles.
  - MUL: WIDTH+1 cycles.
  - op_ready returns the cycle after DONE, so back-to-back accepts are spaced by latency+1.
- busy = (state != IDLE).
- Flags:
  - Z: result == 0. N: result MSB.
  - C for ADD/INC: carry out. C for SUB/DEC: NOT borrow. C for SHL/SHR: bit shifted out. C for MUL: high half nonzero.
  - V for ADD/SUB/INC/DEC: two's-complement overflow. V for MUL: equals C. V for logic ops: 0.
  - Wrap-around: INC of all-ones gives 0 with C=1; DEC of 0 gives all-ones with C=0.
- Bus output:
  - send_result has priority over send_a.
  - bus_out is combinational from the registers.
  - Reading result during busy returns the previous result.

Decomposition:
- Package alu_pkg:
  - opcode_e enum (4-bit) with the encodings above.
  - state_e enum.
  - Flag index constants FLG_Z=0, FLG_N=1, FLG_C=2, FLG_V=3.
- One sub-module, alu_mul_seq:
  - Shift-add multiplier, parametrised by WIDTH.
  - Interface: start, a, b, done, prod[2*WIDTH].
  - Top-level FSM waits on its done.

Test Plan:
1. Reset mid-MUL (A=8'h0D, B=8'h0B, rst_n low at cycle 4) -> all outputs 0, op_ready=1, no result_valid.
2. A=8'h7F, B=8'h01, ADD -> result_valid 2 cycles after accept; result=8'h80; flags V=1, C=0, N=1, Z=0.
3. A=8'h05, B=8'h05, SUB -> result=8'h00; Z=1, C=1, V=0. Then DEC A with A=0 -> 8'hFF, C=0, N=1.
4. A=8'h0D, B=8'h0B, MUL -> result_valid at WIDTH+1=9 cycles, result=8'h8F, C=V=0. Then A=B=8'h10 -> result=8'h00, Z=1, C=V=1.
5. load_a with 8'h33 on the accept cycle of INC (old A=8'h10) -> result=8'h11; A reads back 8'h33 via send_a.
6. op_valid held during MUL -> op_ready=0, no second accept until after DONE. send_result & send_a both high -> bus_out=result, bus_oe=1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the multi-cycle ALU datapath.
//   opcode_e : 4-bit operation encoding (11..15 reserved)
//   state_e  : control FSM states
//   FLG_*    : bit positions inside the 4-bit {V,C,N,Z} flags vector
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOT = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_INC = 4'd8,
        OP_DEC = 4'd9,
        OP_MUL = 4'd10
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_C = 2;
    localparam int FLG_V = 3;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: unsigned shift-add multiplier, one partial product per clock.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load a/b and perform the first (bit 0) iteration this edge
//   a, b       : operands, sampled only on start
//   done       : high from the edge after the last iteration until next start
//   prod       : full 2*WIDTH-bit product, final while done is high
// Iterations run on the start edge plus WIDTH-1 further edges, so done
// rises WIDTH-1 edges after start.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               running;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod    <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else if (start) begin
            // Bit 0 is folded into the load so the whole product takes WIDTH edges.
            prod    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
            mcand   <= {{(WIDTH-1){1'b0}}, a, 1'b0};
            mplier  <= b >> 1;
            cnt     <= CW'(1);
            running <= 1'b1;
            done    <= 1'b0;
        end else if (running) begin
            if (mplier[0]) begin
                prod <= prod + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (cnt == CW'(WIDTH-1)) begin
                running <= 1'b0;
                done    <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_datapath_mc.sv
// alu_datapath_mc: multi-cycle ALU datapath with A/B operand registers,
// registered result and {V,C,N,Z} flags.
//   bus_in, load_a, load_b    : operand loads, honoured in every state
//   op_valid, opcode, op_ready: operation handshake
//   result_valid              : one-cycle pulse when result/flags update
//   busy                      : an operation is in flight
//   flags                     : {V,C,N,Z} of the last completed operation
//   send_result, send_a       : bus read requests (send_result wins)
//   bus_out, bus_oe           : combinational bus drive, bus_out 0 when idle
// Handshake: an operation is accepted on a rising edge where op_valid and
// op_ready are both high; opcode is sampled on that edge only. op_ready is
// high only in IDLE, and op_valid may stay high while op_ready is low
// without effect. The result appears two edges after accept (WIDTH+1 for MUL).
module alu_datapath_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             load_a,
    input  logic             load_b,
    input  logic             op_valid,
    input  logic [OPW-1:0]   opcode,
    output logic             op_ready,
    output logic             result_valid,
    output logic             busy,
    output logic [3:0]       flags,
    input  logic             send_result,
    input  logic             send_a,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_oe
);

    localparam int MSB = WIDTH - 1;

    state_e             state;
    logic [WIDTH-1:0]   a_reg, b_reg;
    logic [WIDTH-1:0]   op_a, op_b;
    opcode_e            op_code;
    logic [WIDTH-1:0]   result;
    logic               accept;
    logic               mul_start, mul_done;
    logic [2*WIDTH-1:0] prod;

    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   rhs, r;
    logic               c, v, rsv;
    logic [WIDTH-1:0]   res_next;
    logic [3:0]         flg_next;

    assign op_ready  = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign accept    = op_valid & op_ready;
    // Multiplier sees the pre-load A/B because loads land on this same edge.
    assign mul_start = accept && (opcode_e'(opcode) == OP_MUL);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .a     (a_reg),
        .b     (b_reg),
        .done  (mul_done),
        .prod  (prod)
    );

    // Result/flag computation from the operand snapshot; only consumed in DONE.
    always_comb begin
        rhs = (op_code == OP_INC || op_code == OP_DEC) ? {{(WIDTH-1){1'b0}}, 1'b1} : op_b;
        sum = '0;
        r   = '0;
        c   = 1'b0;
        v   = 1'b0;
        rsv = 1'b0;
        case (op_code)
            OP_ADD, OP_INC: begin
                sum = {1'b0, op_a} + {1'b0, rhs};
                r   = sum[MSB:0];
                c   = sum[WIDTH];
                v   = (op_a[MSB] == rhs[MSB]) && (r[MSB] != op_a[MSB]);
            end
            OP_SUB, OP_DEC: begin
                sum = {1'b0, op_a} - {1'b0, rhs};
                r   = sum[MSB:0];
                c   = ~sum[WIDTH];  // carry = NOT borrow
                v   = (op_a[MSB] != rhs[MSB]) && (r[MSB] != op_a[MSB]);
            end
            OP_AND: r = op_a & op_b;
            OP_OR:  r = op_a | op_b;
            OP_XOR: r = op_a ^ op_b;
            OP_NOT: r = ~op_a;
            OP_SHL: begin
                r = {op_a[MSB-1:0], 1'b0};
                c = op_a[MSB];
            end
            OP_SHR: begin
                r = {1'b0, op_a[MSB:1]};
                c = op_a[0];
            end
            OP_MUL: begin
                r = prod[MSB:0];
                c = |prod[2*WIDTH-1:WIDTH];
                v = c;
            end
            default: rsv = 1'b1;
        endcase
        res_next        = r;
        flg_next        = '0;
        if (!rsv) begin
            flg_next[FLG_Z] = (r == '0);
            flg_next[FLG_N] = r[MSB];
            flg_next[FLG_C] = c;
            flg_next[FLG_V] = v;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            a_reg        <= '0;
            b_reg        <= '0;
            op_a         <= '0;
            op_b         <= '0;
            op_code      <= OP_ADD;
            result       <= '0;
            flags        <= '0;
            result_valid <= 1'b0;
        end else begin
            if (load_a) a_reg <= bus_in;
            if (load_b) b_reg <= bus_in;
            result_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_a    <= a_reg;
                        op_b    <= b_reg;
                        op_code <= opcode_e'(opcode);
                        state   <= (opcode_e'(opcode) == OP_MUL) ? ST_MUL : ST_EXEC;
                    end
                end
                ST_EXEC: state <= ST_DONE;
                ST_MUL:  if (mul_done) state <= ST_DONE;
                ST_DONE: begin
                    result       <= res_next;
                    flags        <= flg_next;
                    result_valid <= 1'b1;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus_oe  = send_result | send_a;
    assign bus_out = send_result ? result : (send_a ? a_reg : '0);

endmodule

// File: tb/tb_alu_datapath_mc.sv
// Bench for alu_datapath_mc: fixed vector table, hand-written multi-cycle
// sequences, and random operations checked against an arithmetic model.
module tb_alu_datapath_mc;

    localparam int W = 8;

    logic         clk, rst_n;
    logic [W-1:0] bus_in;
    logic         load_a, load_b, op_valid;
    logic [3:0]   opcode;
    logic         op_ready, result_valid, busy;
    logic [3:0]   flags;
    logic         send_result, send_a;
    logic [W-1:0] bus_out;
    logic         bus_oe;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];
    logic [3:0]   flg_q[$];
    logic [W-1:0] sh_a, sh_b;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [3:0]   flg;
    } vec_t;

    alu_datapath_mc #(.WIDTH(W), .OPW(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus_in       (bus_in),
        .load_a       (load_a),
        .load_b       (load_b),
        .op_valid     (op_valid),
        .opcode       (opcode),
        .op_ready     (op_ready),
        .result_valid (result_valid),
        .busy         (busy),
        .flags        (flags),
        .send_result  (send_result),
        .send_a       (send_a),
        .bus_out      (bus_out),
        .bus_oe       (bus_oe)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- check / driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural reference: plain integer arithmetic on the operation rules.
    function automatic void model(input int op, input int a, input int b,
                                  output logic [W-1:0] res, output logic [3:0] flg);
        int full, sa, sb, sfull;
        bit c, v, rsv;
        c = 0; v = 0; rsv = 0; sfull = 0; full = 0;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        case (op)
            0:  begin full = a + b; c = (full > 255); sfull = sa + sb; v = (sfull > 127 || sfull < -128); end
            1:  begin full = a - b; c = (a >= b);     sfull = sa - sb; v = (sfull > 127 || sfull < -128); end
            2:  full = a & b;
            3:  full = a | b;
            4:  full = a ^ b;
            5:  full = 255 - a;
            6:  begin full = a * 2; c = (a >= 128); end
            7:  begin full = a / 2; c = (a % 2 == 1); end
            8:  begin full = a + 1; c = (full > 255); sfull = sa + 1; v = (sfull > 127); end
            9:  begin full = a - 1; c = (a >= 1);     sfull = sa - 1; v = (sfull < -128); end
            10: begin full = a * b; c = (full > 255); v = c; end
            default: rsv = 1;
        endcase
        res = W'(full & 255);
        flg = rsv ? 4'b0000 : {v, c, res[W-1], (res == 0)};
    endfunction

    task automatic load_ab(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus_in = a; load_a = 1'b1;
        @(negedge clk);
        load_a = 1'b0; bus_in = b; load_b = 1'b1;
        @(negedge clk);
        load_b = 1'b0;
        sh_a = a; sh_b = b;
    endtask

    // Issues one op (optionally loading A on the accept edge), waits for the
    // result pulse, and compares latency, result and flags with the scoreboard.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] exp_res,
                          input logic [3:0] exp_flg, input bit with_load,
                          input logic [W-1:0] load_val, input string tag);
        int j;
        int lat_exp;
        logic [W-1:0] er;
        logic [3:0]   ef;
        lat_exp = (op == 4'd10) ? W + 1 : 2;
        exp_q.push_back(exp_res);
        flg_q.push_back(exp_flg);
        @(negedge clk);
        check({tag, "_ready"}, {31'd0, op_ready}, 32'd1);
        op_valid = 1'b1; opcode = op;
        if (with_load) begin
            load_a = 1'b1; bus_in = load_val;
        end
        @(negedge clk);
        op_valid = 1'b0; load_a = 1'b0;
        if (with_load) sh_a = load_val;
        j = 0;
        while (!result_valid && j < 40) begin
            @(negedge clk);
            j++;
        end
        check({tag, "_latency"}, j, lat_exp);
        er = exp_q.pop_front();
        ef = flg_q.pop_front();
        send_result = 1'b1;
        #1;
        check({tag, "_result"}, {24'd0, bus_out}, {24'd0, er});
        check({tag, "_flags"}, {28'd0, flags}, {28'd0, ef});
        send_result = 1'b0;
        @(negedge clk);
        check({tag, "_pulse"}, {31'd0, result_valid}, 32'd0);
    endtask

    // ---------------- main sequence ----------------
    vec_t vecs[16];

    initial begin
        int rv_cnt, first_rv, second_rv, ready_viol;
        logic [W-1:0] mr;
        logic [3:0]   mf;
        logic [3:0]   rop;

        vecs[0]  = '{4'd0,  8'h7F, 8'h01, 8'h80, 4'b1010};
        vecs[1]  = '{4'd1,  8'h05, 8'h05, 8'h00, 4'b0101};
        vecs[2]  = '{4'd9,  8'h00, 8'h00, 8'hFF, 4'b0010};
        vecs[3]  = '{4'd10, 8'h0D, 8'h0B, 8'h8F, 4'b0010};
        vecs[4]  = '{4'd10, 8'h10, 8'h10, 8'h00, 4'b1101};
        vecs[5]  = '{4'd8,  8'hFF, 8'h00, 8'h00, 4'b0101};
        vecs[6]  = '{4'd6,  8'h81, 8'h00, 8'h02, 4'b0100};
        vecs[7]  = '{4'd7,  8'h81, 8'h00, 8'h40, 4'b0100};
        vecs[8]  = '{4'd5,  8'h0F, 8'h00, 8'hF0, 4'b0010};
        vecs[9]  = '{4'd4,  8'hAA, 8'hFF, 8'h55, 4'b0000};
        vecs[10] = '{4'd12, 8'hFF, 8'h01, 8'h00, 4'b0000};
        vecs[11] = '{4'd1,  8'h80, 8'h01, 8'h7F, 4'b1100};
        vecs[12] = '{4'd8,  8'h7F, 8'h00, 8'h80, 4'b1010};
        vecs[13] = '{4'd9,  8'h80, 8'h00, 8'h7F, 4'b1100};
        vecs[14] = '{4'd2,  8'hF0, 8'h3C, 8'h30, 4'b0000};
        vecs[15] = '{4'd3,  8'h00, 8'h00, 8'h00, 4'b0001};

        // reset
        rst_n = 1'b0; bus_in = '0; load_a = 0; load_b = 0; op_valid = 0;
        opcode = '0; send_result = 0; send_a = 0; sh_a = '0; sh_b = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, op_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rvalid", {31'd0, result_valid}, 32'd0);
        check("rst_flags", {28'd0, flags}, 32'd0);
        check("rst_bus", {23'd0, bus_oe, bus_out}, 32'd0);
        rst_n = 1'b1;

        // table-driven vectors
        for (int i = 0; i < 16; i++) begin
            load_ab(vecs[i].a, vecs[i].b);
            run_op(vecs[i].op, vecs[i].res, vecs[i].flg, 1'b0, '0, $sformatf("vec%0d", i));
        end

        // reset in the middle of a MUL: no pulse, everything cleared
        load_ab(8'h0D, 8'h0B);
        @(negedge clk);
        op_valid = 1'b1; opcode = 4'd10;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midmul_busy", {31'd0, busy}, 32'd0);
        check("midmul_ready", {31'd0, op_ready}, 32'd1);
        check("midmul_flags", {28'd0, flags}, 32'd0);
        send_result = 1'b1; #1;
        check("midmul_result", {24'd0, bus_out}, 32'd0);
        send_result = 1'b0; send_a = 1'b1; #1;
        check("midmul_a", {24'd0, bus_out}, 32'd0);
        send_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sh_a = '0; sh_b = '0;
        rv_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (result_valid) rv_cnt++;
        end
        check("midmul_no_pulse", rv_cnt, 0);

        // load A on the accept edge of INC: op must see the old A
        load_ab(8'h10, 8'h00);
        run_op(4'd8, 8'h11, 4'b0000, 1'b1, 8'h33, "inc_load");
        send_a = 1'b1; #1;
        check("inc_load_a_readback", {24'd0, bus_out}, 32'h33);
        check("inc_load_a_oe", {31'd0, bus_oe}, 32'd1);
        send_a = 1'b0; #1;
        check("bus_idle", {23'd0, bus_oe, bus_out}, 32'd0);

        // op_valid held through two MULs: accepts spaced by latency+1
        load_ab(8'h0D, 8'h0B);
        @(negedge clk);
        op_valid = 1'b1; opcode = 4'd10;
        first_rv = -1; second_rv = -1; ready_viol = 0;
        for (int j = 0; j < 40 && second_rv < 0; j++) begin
            @(negedge clk);
            if (busy && op_ready) ready_viol++;
            if (result_valid) begin
                if (first_rv < 0) first_rv = j;
                else begin
                    second_rv = j;
                    op_valid = 1'b0;
                end
            end
        end
        op_valid = 1'b0;
        check("held_first_latency", first_rv, W + 1);
        check("held_spacing", second_rv - first_rv, W + 2);
        check("held_ready_low_while_busy", ready_viol, 0);
        send_result = 1'b1; send_a = 1'b1; #1;
        check("prio_bus_out", {24'd0, bus_out}, 32'h8F);
        check("prio_oe", {31'd0, bus_oe}, 32'd1);
        send_result = 1'b0; send_a = 1'b0;
        @(negedge clk);
        check("held_no_third", {31'd0, busy}, 32'd0);

        // random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            rop = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) load_ab(ra, rb);
            model(int'(rop), int'(sh_a), int'(sh_b), mr, mf);
            run_op(rop, mr, mf, 1'b0, '0, $sformatf("rnd%0d_op%0d", i, rop));
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
